// File: rtl/bht_predictor_pkg.sv
// Shared fetch-stage constants: RV32I opcodes, branch funct3 codes and BHT defaults.
package bht_predictor_pkg;

  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;

  localparam logic [1:0] BHT_CNT_SNT = 2'b00;
  localparam logic [1:0] BHT_CNT_WNT = 2'b01;
  localparam logic [1:0] BHT_CNT_WT  = 2'b10;
  localparam logic [1:0] BHT_CNT_ST  = 2'b11;

  localparam int BHT_ENTRIES = 64;

endpackage

// File: rtl/bht_predictor_table.sv
// Array of saturating direction counters with asynchronous reset to weakly-not-taken.
module bht_table
  import bht_predictor_pkg::*;
#(
  parameter int ENTRIES  = BHT_ENTRIES,
  parameter int CNT_BITS = 2,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [CNT_BITS-1:0] rd_cnt,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic                wr_taken
);

  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic [CNT_BITS-1:0] cnt_q [ENTRIES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_WNT;
    end else if (wr_en) begin
      if (wr_taken && (cnt_q[wr_idx] != CNT_MAX))
        cnt_q[wr_idx] <= cnt_q[wr_idx] + 1'b1;
      else if (!wr_taken && (cnt_q[wr_idx] != '0))
        cnt_q[wr_idx] <= cnt_q[wr_idx] - 1'b1;
    end
  end

  // Read is the registered value: a same-edge write is not forwarded.
  assign rd_cnt = cnt_q[rd_idx];

endmodule

// File: rtl/bht_predictor.sv
// Fetch-stage branch predictor: combinational decode/lookup/target, BHT trained from execute.
module bht_predictor
  import bht_predictor_pkg::*;
#(
  parameter int ENTRIES  = BHT_ENTRIES,
  parameter int CNT_BITS = 2,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       instruction_i,
  input  logic [31:0]       pc_i,
  output logic              br_pred_o,
  output logic [31:0]       new_pc_pred_o,
  input  logic              upd_valid_i,
  input  logic [31:0]       upd_pc_i,
  input  logic              upd_taken_i,
  input  logic              miss_pred_i,
  output logic [PERF_W-1:0] miss_count_o
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic                is_cond;
  logic                is_jal;
  logic [31:0]         imm_b;
  logic [31:0]         imm_j;
  logic [IDX_W-1:0]    rd_idx;
  logic [IDX_W-1:0]    wr_idx;
  logic [CNT_BITS-1:0] rd_cnt;
  logic                cnt_unused;
  logic                upd_pc_unused;

  assign opcode = instruction_i[6:0];
  assign funct3 = instruction_i[14:12];

  always_comb begin
    is_cond = 1'b0;
    if (opcode == OPCODE_BRANCH) begin
      case (funct3)
        FUNCT3_BEQ, FUNCT3_BNE, FUNCT3_BLT,
        FUNCT3_BGE, FUNCT3_BLTU, FUNCT3_BGEU: is_cond = 1'b1;
        default:                              is_cond = 1'b0;
      endcase
    end
  end

  assign is_jal = (opcode == OPCODE_JAL);

  assign imm_b = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                  instruction_i[30:25], instruction_i[11:8], 1'b0};
  assign imm_j = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                  instruction_i[20], instruction_i[30:21], 1'b0};

  assign rd_idx = pc_i[IDX_W+1:2];
  assign wr_idx = upd_pc_i[IDX_W+1:2];

  // Only the counter MSB and the index bits of the update PC carry meaning here.
  assign cnt_unused    = ^rd_cnt;
  assign upd_pc_unused = ^{upd_pc_i[31:IDX_W+2], upd_pc_i[1:0]};

  bht_table #(
    .ENTRIES  (ENTRIES),
    .CNT_BITS (CNT_BITS)
  ) u_table (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_idx   (rd_idx),
    .rd_cnt   (rd_cnt),
    .wr_en    (upd_valid_i),
    .wr_idx   (wr_idx),
    .wr_taken (upd_taken_i)
  );

  always_comb begin
    br_pred_o     = 1'b0;
    new_pc_pred_o = pc_i + 32'd4;
    if (is_jal) begin
      br_pred_o     = 1'b1;
      new_pc_pred_o = pc_i + imm_j;
    end else if (is_cond && rd_cnt[CNT_BITS-1]) begin
      br_pred_o     = 1'b1;
      new_pc_pred_o = pc_i + imm_b;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      miss_count_o <= '0;
    else if (miss_pred_i && (miss_count_o != '1))
      miss_count_o <= miss_count_o + 1'b1;
  end

endmodule

// File: tb/tb_bht_predictor.sv
// Directed bench for bht_predictor (ENTRIES=64, CNT_BITS=2, PERF_W=3).
module tb_bht_predictor;

  logic        clk;
  logic        reset_n;
  logic [31:0] instruction_i;
  logic [31:0] pc_i;
  logic        br_pred_o;
  logic [31:0] new_pc_pred_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic        miss_pred_i;
  logic [2:0]  miss_count_o;

  int n_checks;
  int n_fail;

  bht_predictor #(
    .ENTRIES  (64),
    .CNT_BITS (2),
    .PERF_W   (3)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .instruction_i (instruction_i),
    .pc_i          (pc_i),
    .br_pred_o     (br_pred_o),
    .new_pc_pred_o (new_pc_pred_o),
    .upd_valid_i   (upd_valid_i),
    .upd_pc_i      (upd_pc_i),
    .upd_taken_i   (upd_taken_i),
    .miss_pred_i   (miss_pred_i),
    .miss_count_o  (miss_count_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic train(input logic [31:0] pc, input logic taken, input int n);
    for (int i = 0; i < n; i++) begin
      upd_valid_i = 1'b1;
      upd_pc_i    = pc;
      upd_taken_i = taken;
      tick();
    end
    upd_valid_i = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] instr, input logic [31:0] pc);
    instruction_i = instr;
    pc_i          = pc;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    lookup(enc_b(3'b000, 13'd16), 32'h100);
    n_checks++;
    if (br_pred_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_pred got=%b exp=0", br_pred_o);
    end
    n_checks++;
    if (new_pc_pred_o !== 32'h104) begin
      n_fail++; $display("FAIL reset_npc got=%h exp=00000104", new_pc_pred_o);
    end
    n_checks++;
    if (miss_count_o !== 3'd0) begin
      n_fail++; $display("FAIL reset_miss got=%0d exp=0", miss_count_o);
    end
  endtask

  task automatic test_single_train();
    train(32'h100, 1'b1, 1);
    lookup(enc_b(3'b000, 13'd16), 32'h100);
    n_checks++;
    if (br_pred_o !== 1'b1) begin
      n_fail++; $display("FAIL train1_pred got=%b exp=1", br_pred_o);
    end
    n_checks++;
    if (new_pc_pred_o !== 32'h110) begin
      n_fail++; $display("FAIL train1_npc got=%h exp=00000110", new_pc_pred_o);
    end
  endtask

  task automatic check_pred(input string name, input logic exp);
    n_checks++;
    if (br_pred_o !== exp) begin
      n_fail++; $display("FAIL %s got=%b exp=%b", name, br_pred_o, exp);
    end
  endtask

  task automatic test_saturation();
    lookup(enc_b(3'b001, 13'd16), 32'h100);
    train(32'h100, 1'b1, 5);
    check_pred("sat_st", 1'b1);
    train(32'h100, 1'b0, 1);
    check_pred("hyst_wt", 1'b1);
    train(32'h100, 1'b0, 1);
    check_pred("hyst_wnt", 1'b0);
    train(32'h100, 1'b0, 4);
    check_pred("sat_snt", 1'b0);
    train(32'h100, 1'b1, 1);
    check_pred("from_snt_1", 1'b0);
    train(32'h100, 1'b1, 1);
    check_pred("from_snt_2", 1'b1);
  endtask

  task automatic test_jal_jalr_funct3();
    lookup(enc_j(21'h00020), 32'hFFFF_FFF0);
    check_pred("jal_pred", 1'b1);
    n_checks++;
    if (new_pc_pred_o !== 32'h0000_0010) begin
      n_fail++; $display("FAIL jal_wrap_npc got=%h exp=00000010", new_pc_pred_o);
    end
    // idx 10 trained to strongly taken so non-branches cannot borrow its prediction
    train(32'h028, 1'b1, 2);
    lookup(32'h0000_80E7, 32'h028);
    check_pred("jalr_pred", 1'b0);
    n_checks++;
    if (new_pc_pred_o !== 32'h02C) begin
      n_fail++; $display("FAIL jalr_npc got=%h exp=0000002c", new_pc_pred_o);
    end
    lookup(enc_b(3'b010, 13'd16), 32'h028);
    check_pred("f3_010_pred", 1'b0);
    n_checks++;
    if (new_pc_pred_o !== 32'h02C) begin
      n_fail++; $display("FAIL f3_010_npc got=%h exp=0000002c", new_pc_pred_o);
    end
    lookup(enc_b(3'b011, 13'd16), 32'h028);
    check_pred("f3_011_pred", 1'b0);
    lookup(enc_b(3'b111, 13'h1FF8), 32'h028);
    check_pred("bgeu_neg_pred", 1'b1);
    n_checks++;
    if (new_pc_pred_o !== 32'h020) begin
      n_fail++; $display("FAIL bgeu_neg_npc got=%h exp=00000020", new_pc_pred_o);
    end
  endtask

  task automatic test_collision_alias();
    instruction_i = enc_b(3'b100, 13'd64);
    pc_i          = 32'h014;
    upd_valid_i   = 1'b1;
    upd_pc_i      = 32'h014;
    upd_taken_i   = 1'b1;
    #1;
    check_pred("collide_old", 1'b0);
    tick();
    upd_valid_i = 1'b0;
    check_pred("collide_new", 1'b1);
    n_checks++;
    if (new_pc_pred_o !== 32'h054) begin
      n_fail++; $display("FAIL collide_npc got=%h exp=00000054", new_pc_pred_o);
    end
    lookup(enc_b(3'b100, 13'd64), 32'h114);
    check_pred("alias_read", 1'b1);
    train(32'h114, 1'b0, 1);
    lookup(enc_b(3'b100, 13'd64), 32'h014);
    check_pred("alias_write", 1'b0);
    lookup(enc_b(3'b100, 13'd64), 32'h018);
    check_pred("neighbour_idx6", 1'b0);
  endtask

  task automatic test_async_reset_perf();
    train(32'h014, 1'b1, 2);
    train(32'h100, 1'b1, 1);
    miss_pred_i = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    miss_pred_i = 1'b0;
    n_checks++;
    if (miss_count_o !== 3'd7) begin
      n_fail++; $display("FAIL miss_seven got=%0d exp=7", miss_count_o);
    end
    lookup(enc_b(3'b000, 13'd16), 32'h014);
    check_pred("pre_reset_st", 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    check_pred("async_idx5", 1'b0);
    n_checks++;
    if (miss_count_o !== 3'd0) begin
      n_fail++; $display("FAIL async_miss got=%0d exp=0", miss_count_o);
    end
    lookup(enc_b(3'b000, 13'd16), 32'h100);
    check_pred("async_idx0", 1'b0);
    reset_n = 1'b1;
    tick();
    train(32'h014, 1'b1, 1);
    lookup(enc_b(3'b000, 13'd16), 32'h014);
    check_pred("post_reset_wnt", 1'b1);
    upd_valid_i = 1'b1;
    upd_pc_i    = 32'h200;
    upd_taken_i = 1'b0;
    miss_pred_i = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    miss_pred_i = 1'b0;
    upd_valid_i = 1'b0;
    n_checks++;
    if (miss_count_o !== 3'd7) begin
      n_fail++; $display("FAIL miss_saturate got=%0d exp=7", miss_count_o);
    end
  endtask

  task automatic test_back_to_back_miss_only();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    tick();
    miss_pred_i = 1'b1;
    tick();
    tick();
    tick();
    miss_pred_i = 1'b0;
    tick();
    n_checks++;
    if (miss_count_o !== 3'd3) begin
      n_fail++; $display("FAIL miss_three got=%0d exp=3", miss_count_o);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset_n       = 1'b0;
    instruction_i = 32'h0000_0013;
    pc_i          = 32'h0;
    upd_valid_i   = 1'b0;
    upd_pc_i      = 32'h0;
    upd_taken_i   = 1'b0;
    miss_pred_i   = 1'b0;
    test_reset();
    test_single_train();
    test_saturation();
    test_jal_jalr_funct3();
    test_collision_alias();
    test_async_reset_perf();
    test_back_to_back_miss_only();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
